sram_port_arb: RTL and testbench
================================

SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-003 i_req  input  1  instruction-fetch read request; held with i_addr stable until i_gnt.
REQ-004 i_addr  input  32  fetch address.
REQ-005 i_gnt  output  1  fetch request accepted this cycle.
REQ-006 i_rvalid  output  1  i_rdata valid, one cycle after i_gnt.
REQ-007 i_rdata  output  32  fetch read data.
REQ-008 d_req  input  1  data request; d_we, d_addr, d_wdata held stable until d_gnt.
REQ-009 d_we  input  1  1 = store, 0 = load.
REQ-010 d_addr  input  32  data address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_gnt  output  1  data request accepted this cycle.
REQ-013 d_rvalid  output  1  d_rdata valid, one cycle after a load grant; never set for stores.
REQ-014 d_rdata  output  32  load read data.
REQ-015 sram_en  output  1  single shared SRAM port access strobe.
REQ-016 sram_we  output  1  SRAM write enable; only asserted with sram_en.
REQ-017 sram_addr  output  32  SRAM address.
REQ-018 sram_wdata  output  32  SRAM write data.
REQ-019 sram_rdata  input  32  SRAM read data, registered one cycle after a read strobe.
REQ-020 conflict_cnt  output  16  saturating count of cycles with i_req and d_req both high.

Function
REQ-021 At most one grant per cycle; grant is combinational on the request in the same cycle; SRAM access is driven that same cycle from the winner.
REQ-022 Single requester: grant immediately, no bubble; back-to-back grants every cycle are allowed.
REQ-023 Contention, default policy: d_req wins; i_req is held off and granted in the first cycle d_req is low.
REQ-024 sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0 when there is no grant.
REQ-025 Return tracker FSM states: IDLE, RET_I, RET_D; any cycle with i_gnt -> RET_I; load d_gnt -> RET_D; no grant or store grant -> IDLE.
REQ-026 RET_I: i_rvalid=1, i_rdata=sram_rdata; RET_D: d_rvalid=1, d_rdata=sram_rdata; the rdata of the side not in a RET state is 0.
REQ-027 A new grant is allowed while in a RET state; return and new access overlap (pipelined, read latency exactly 1).
REQ-028 conflict_cnt increments by 1 per contention cycle, holds at 16'hFFFF, never wraps.
REQ-029 Grants are qualified by no other state; requests that deassert before grant are dropped without side effects.

Reset
REQ-030 In reset: FSM to IDLE, i_gnt, d_gnt, i_rvalid, d_rvalid = 0, sram_en = 0, conflict_cnt = 0, priority pointer = data.
REQ-031 Reset asserted while a read is outstanding discards it: no rvalid in the cycle after reset deasserts.

Configuration
REQ-032 Macro SRAM_ARB_RR_EN defined: round-robin; on contention, the side not granted most recently wins, so continuous contention alternates D,I,D,I starting with D after reset.
REQ-033 SRAM_ARB_RR_EN undefined: fixed data-over-instruction priority per REQ-023; the priority pointer is not built.

Structure
REQ-034 Shared package holds the FSM state enum (IDLE, RET_I, RET_D), ADDR_W=32, DATA_W=32, and CNT_W=16.
REQ-035 One sub-module, sram_arb_pick, holds the combinational grant selection (inputs: both requests, pointer; outputs: one-hot grant); all sequential state stays in the top.

Verification
REQ-036 i_req only, i_addr=0x1C000000, sram_rdata=0x02800421 next cycle -> i_gnt same cycle, i_rvalid next cycle with i_rdata=0x02800421.
REQ-037 Both requests, d_we=0, d_addr=0x100, i_addr=0x1C000004 held 2 cycles -> cycle0 d_gnt with sram_addr=0x100, cycle1 i_gnt with d_rvalid=1, cycle2 i_rvalid=1; conflict_cnt=1.
REQ-038 Store d_we=1, d_addr=0x8, d_wdata=0xDEADBEEF -> sram_we=1, sram_wdata=0xDEADBEEF, no d_rvalid next cycle.
REQ-039 Continuous contention for 6 cycles -> default: 6 d_gnt and 0 i_gnt; SRAM_ARB_RR_EN: D,I,D,I,D,I.
REQ-040 Load granted, reset asserted next cycle -> d_rvalid=0 throughout and after reset; conflict_cnt=0.
REQ-041 Force contention for 70000 cycles -> conflict_cnt stays at 0xFFFF.

Source files
------------

// File: rtl/sram_port_arb_pkg.sv
// Shared types and widths for the SRAM port arbiter slice.
package sram_port_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  // Read-return tracker: which side owns the data arriving next cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RET_I = 2'd1,
    RET_D = 2'd2
  } ret_state_t;

  // One-hot grant encoding: bit 0 = fetch side, bit 1 = data side.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/sram_port_arb_if.sv
// Requester-side bus of the SRAM port arbiter: fetch and data handshakes.
import sram_port_arb_pkg::*;

interface sram_port_arb_if;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // Requesters (fetch unit / load-store unit).
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata
  );

  // Arbiter.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata
  );

endinterface

// File: rtl/sram_arb_pick.sv
// Combinational grant selection between fetch and data requests.
// i_ptr_d = 1 gives the data side priority on contention.
import sram_port_arb_pkg::*;

module sram_arb_pick (
  input  logic       i_ireq,
  input  logic       i_dreq,
  input  logic       i_ptr_d,
  output logic [1:0] o_gnt
);

  // Single requester always wins; on contention the pointer decides.
  always_comb begin
    o_gnt = GNT_NONE;
    if (i_dreq && (!i_ireq || i_ptr_d)) begin
      o_gnt = GNT_D;
    end else if (i_ireq) begin
      o_gnt = GNT_I;
    end
  end

endmodule

// File: rtl/sram_port_arb.sv
// Two-requester arbiter onto one single-port SRAM (read latency 1).
// Optional feature macro: SRAM_ARB_RR_EN (round-robin on contention);
// without it the data side always wins contention.
import sram_port_arb_pkg::*;

module sram_port_arb (
  input  logic                 clk,
  input  logic                 reset,
  sram_port_arb_if.slave       bus,
  output logic                 sram_en,
  output logic                 sram_we,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [DATA_W-1:0]    sram_wdata,
  input  logic [DATA_W-1:0]    sram_rdata,
  output logic [CNT_W-1:0]     conflict_cnt
);

  logic [1:0]       w_pick_gnt;
  logic [1:0]       w_gnt;
  logic             w_ptr_d;
  logic             w_conflict;
  ret_state_t       r_state;
  logic [CNT_W-1:0] r_conflict_cnt;

  assign w_conflict = bus.i_req & bus.d_req & ~reset;

`ifdef SRAM_ARB_RR_EN
  logic r_ptr_d;

  // Priority pointer: the side not granted most recently wins next contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr_d <= 1'b1;
    end else if (w_gnt[1]) begin
      r_ptr_d <= 1'b0;
    end else if (w_gnt[0]) begin
      r_ptr_d <= 1'b1;
    end
  end

  assign w_ptr_d = r_ptr_d;
`else
  assign w_ptr_d = 1'b1;
`endif

  sram_arb_pick u_pick (
    .i_ireq  (bus.i_req),
    .i_dreq  (bus.d_req),
    .i_ptr_d (w_ptr_d),
    .o_gnt   (w_pick_gnt)
  );

  // Grants are suppressed while reset is held.
  assign w_gnt = reset ? GNT_NONE : w_pick_gnt;

  // Drive grants and the shared SRAM port from the winner; all zero when idle.
  always_comb begin
    bus.i_gnt  = w_gnt[0];
    bus.d_gnt  = w_gnt[1];
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (w_gnt[1]) begin
      sram_en    = 1'b1;
      sram_we    = bus.d_we;
      sram_addr  = bus.d_addr;
      sram_wdata = bus.d_wdata;
    end else if (w_gnt[0]) begin
      sram_en    = 1'b1;
      sram_addr  = bus.i_addr;
    end
  end

  // Return tracker: remembers which side's read is returning next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (w_gnt[0]) begin
      r_state <= RET_I;
    end else if (w_gnt[1] && !bus.d_we) begin
      r_state <= RET_D;
    end else begin
      r_state <= IDLE;
    end
  end

  // Route returning SRAM data to its owner; reset masks a stale return.
  always_comb begin
    bus.i_rvalid = 1'b0;
    bus.d_rvalid = 1'b0;
    bus.i_rdata  = '0;
    bus.d_rdata  = '0;
    if (!reset) begin
      if (r_state == RET_I) begin
        bus.i_rvalid = 1'b1;
        bus.i_rdata  = sram_rdata;
      end else if (r_state == RET_D) begin
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = sram_rdata;
      end
    end
  end

  // Saturating count of cycles with both requests high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed testbench for sram_port_arb (table vectors plus multi-cycle sequences).
module tb_sram_port_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_en, sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [15:0] conflict_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  sram_port_arb_if bus ();

  sram_port_arb dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .conflict_cnt (conflict_cnt)
  );

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] srdata;
    logic        igt, dgt, irv, drv;
    logic [31:0] irdata, drdata;
    logic        sen, swe;
    logic [31:0] saddr, swdata;
  } vec_t;

  function automatic vec_t mkv(
    input logic rst, input logic ireq, input logic [31:0] iaddr,
    input logic dreq, input logic dwe, input logic [31:0] daddr,
    input logic [31:0] dwdata, input logic [31:0] srdata,
    input logic igt, input logic dgt, input logic irv, input logic drv,
    input logic [31:0] irdata, input logic [31:0] drdata,
    input logic sen, input logic swe, input logic [31:0] saddr,
    input logic [31:0] swdata);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
    v.daddr = daddr; v.dwdata = dwdata; v.srdata = srdata;
    v.igt = igt; v.dgt = dgt; v.irv = irv; v.drv = drv;
    v.irdata = irdata; v.drdata = drdata; v.sen = sen; v.swe = swe;
    v.saddr = saddr; v.swdata = swdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwe, input logic [31:0] daddr,
                       input logic [31:0] dwdata, input logic [31:0] srdata);
    reset        = rst;
    bus.i_req    = ireq;
    bus.i_addr   = iaddr;
    bus.d_req    = dreq;
    bus.d_we     = dwe;
    bus.d_addr   = daddr;
    bus.d_wdata  = dwdata;
    sram_rdata   = srdata;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    tick();
  endtask

  vec_t vt[17];

  initial begin
    apply(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    tick();

    //            rst ireq iaddr         dreq we daddr     dwdata        srdata        igt dgt irv drv irdata        drdata        sen swe saddr         swdata
    vt[0]  = mkv(1, 0, 32'h0,         0, 0, 32'h0,   32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0);
    vt[1]  = mkv(1, 1, 32'h1C000000,  1, 0, 32'h100, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0);
    vt[2]  = mkv(0, 1, 32'h1C000000,  0, 0, 32'h0,   32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h1C000000, 32'h0);
    vt[3]  = mkv(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,        32'h02800421, 0, 0, 1, 0, 32'h02800421, 32'h0,        0, 0, 32'h0,        32'h0);
    vt[4]  = mkv(0, 1, 32'h1C000004,  1, 0, 32'h100, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,        32'h0,        1, 0, 32'h100,      32'h0);
    vt[5]  = mkv(0, 1, 32'h1C000004,  0, 0, 32'h0,   32'h0,        32'hAAAA5555, 1, 0, 0, 1, 32'h0,        32'hAAAA5555, 1, 0, 32'h1C000004, 32'h0);
    vt[6]  = mkv(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,        32'h12345678, 0, 0, 1, 0, 32'h12345678, 32'h0,        0, 0, 32'h0,        32'h0);
    vt[7]  = mkv(0, 0, 32'h0,         1, 1, 32'h8,   32'hDEADBEEF, 32'h0,        0, 1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h8,        32'hDEADBEEF);
    vt[8]  = mkv(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,        32'hFFFFFFFF, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0);
    vt[9]  = mkv(0, 1, 32'h40,        0, 0, 32'h0,   32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h40,       32'h0);
    vt[10] = mkv(0, 1, 32'h44,        0, 0, 32'h0,   32'h0,        32'h11,       1, 0, 1, 0, 32'h11,       32'h0,        1, 0, 32'h44,       32'h0);
    vt[11] = mkv(0, 0, 32'h0,         1, 0, 32'h200, 32'h0,        32'h22,       0, 1, 1, 0, 32'h22,       32'h0,        1, 0, 32'h200,      32'h0);
    vt[12] = mkv(0, 0, 32'h0,         1, 0, 32'h204, 32'h0,        32'h33,       0, 1, 0, 1, 32'h0,        32'h33,       1, 0, 32'h204,      32'h0);
    vt[13] = mkv(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,        32'h44,       0, 0, 0, 1, 32'h0,        32'h44,       0, 0, 32'h0,        32'h0);
    vt[14] = mkv(0, 0, 32'h0,         1, 0, 32'h300, 32'h0,        32'h55,       0, 1, 0, 0, 32'h0,        32'h0,        1, 0, 32'h300,      32'h0);
    vt[15] = mkv(0, 0, 32'h0,         1, 1, 32'h304, 32'hCAFEF00D, 32'h66,       0, 1, 0, 1, 32'h0,        32'h66,       1, 1, 32'h304,      32'hCAFEF00D);
    vt[16] = mkv(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,        32'h77,       0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0);

    for (int k = 0; k < 17; k++) begin
      apply(vt[k].rst, vt[k].ireq, vt[k].iaddr, vt[k].dreq, vt[k].dwe,
            vt[k].daddr, vt[k].dwdata, vt[k].srdata);
      @(negedge clk);
      chk($sformatf("v%0d i_gnt", k),      {31'b0, bus.i_gnt},    {31'b0, vt[k].igt});
      chk($sformatf("v%0d d_gnt", k),      {31'b0, bus.d_gnt},    {31'b0, vt[k].dgt});
      chk($sformatf("v%0d i_rvalid", k),   {31'b0, bus.i_rvalid}, {31'b0, vt[k].irv});
      chk($sformatf("v%0d d_rvalid", k),   {31'b0, bus.d_rvalid}, {31'b0, vt[k].drv});
      chk($sformatf("v%0d i_rdata", k),    bus.i_rdata,           vt[k].irdata);
      chk($sformatf("v%0d d_rdata", k),    bus.d_rdata,           vt[k].drdata);
      chk($sformatf("v%0d sram_en", k),    {31'b0, sram_en},      {31'b0, vt[k].sen});
      chk($sformatf("v%0d sram_we", k),    {31'b0, sram_we},      {31'b0, vt[k].swe});
      chk($sformatf("v%0d sram_addr", k),  sram_addr,             vt[k].saddr);
      chk($sformatf("v%0d sram_wdata", k), sram_wdata,            vt[k].swdata);
      if (k == 0) chk("reset conflict_cnt", {16'b0, conflict_cnt}, 32'd0);
      tick();
    end
    // Only vt[4] had both requests high outside reset.
    chk("table conflict_cnt", {16'b0, conflict_cnt}, 32'd1);

    // Six cycles of continuous contention.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      logic exp_d;
`ifdef SRAM_ARB_RR_EN
      exp_d = ((c % 2) == 0);
`else
      exp_d = 1'b1;
`endif
      apply(1'b0, 1'b1, 32'h1000 + 32'(4 * c), 1'b1, 1'b0, 32'h2000 + 32'(4 * c), '0, '0);
      @(negedge clk);
      chk($sformatf("cont%0d d_gnt", c), {31'b0, bus.d_gnt}, {31'b0, exp_d});
      chk($sformatf("cont%0d i_gnt", c), {31'b0, bus.i_gnt}, {31'b0, ~exp_d});
      chk($sformatf("cont%0d sram_addr", c), sram_addr,
          exp_d ? 32'h2000 + 32'(4 * c) : 32'h1000 + 32'(4 * c));
      tick();
    end
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    chk("cont conflict_cnt", {16'b0, conflict_cnt}, 32'd6);

    // Losing fetch request withdrawn before grant leaves no trace.
    do_reset();
    apply(1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 32'h600, '0, '0);
    @(negedge clk);
    chk("drop c0 d_gnt", {31'b0, bus.d_gnt}, 32'd1);
    tick();
    apply(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h604, '0, 32'h9);
    @(negedge clk);
    chk("drop c1 i_gnt", {31'b0, bus.i_gnt}, 32'd0);
    chk("drop c1 sram_addr", sram_addr, 32'h604);
    chk("drop c1 d_rvalid", {31'b0, bus.d_rvalid}, 32'd1);
    tick();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 32'hA);
    @(negedge clk);
    chk("drop c2 i_rvalid", {31'b0, bus.i_rvalid}, 32'd0);
    chk("drop c2 d_rdata", bus.d_rdata, 32'hA);
    tick();

    // Reset arriving while a load return is outstanding.
    do_reset();
    apply(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h700, '0, '0);
    @(negedge clk);
    chk("rst c0 d_gnt", {31'b0, bus.d_gnt}, 32'd1);
    tick();
    apply(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 32'h99);
    @(negedge clk);
    chk("rst c1 d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
    chk("rst c1 d_rdata", bus.d_rdata, 32'd0);
    tick();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 32'h99);
    @(negedge clk);
    chk("rst c2 d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
    chk("rst c2 conflict_cnt", {16'b0, conflict_cnt}, 32'd0);
    tick();

    // Counter saturation under long contention.
    do_reset();
    apply(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, '0, '0);
    for (int k = 1; k <= 70000; k++) begin
      tick();
      if (k == 65534) chk("sat 65534", {16'b0, conflict_cnt}, 32'h0000FFFE);
      if (k == 65535) chk("sat 65535", {16'b0, conflict_cnt}, 32'h0000FFFF);
    end
    chk("sat 70000", {16'b0, conflict_cnt}, 32'h0000FFFF);
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("sat hold", {16'b0, conflict_cnt}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
